// File: rtl/weight_ram_loader.sv
// Byte-stream to RAM writer: packs little-endian byte pairs into 16-bit words and
// writes them to consecutive (wrapping) addresses from a latched base, with a running checksum.
module weight_ram_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W:0]   i_length,
  input  logic              i_in_valid,
  input  logic [7:0]        i_in_byte,
  output logic              o_in_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [15:0]       o_checksum
);

  typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_WR, S_DONE} state_t;

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_t              r_state;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W:0]     r_len;
  logic [ADDR_W:0]     r_count;
  logic [7:0]          r_lo;
  logic                r_in_ready;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
  logic [15:0]         r_checksum;

  logic                w_len_ok;
  logic [DATA_W-1:0]   w_word;
  logic [ADDR_W:0]     w_count_next;

  assign w_len_ok     = (i_length != '0) && (i_length <= MAX_LEN);
  assign w_word       = {i_in_byte, r_lo};
  assign w_count_next = r_count + 1'b1;

  // Outputs are set on the transition into each state so they are true registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_len      <= '0;
      r_count    <= '0;
      r_lo       <= '0;
      r_in_ready <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_checksum <= '0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (w_len_ok) begin
              r_base     <= i_base_addr;
              r_len      <= i_length;
              r_count    <= '0;
              r_checksum <= '0;
              r_error    <= 1'b0;
              r_busy     <= 1'b1;
              r_in_ready <= 1'b1;
              r_state    <= S_LO;
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        S_LO: begin
          if (i_abort) begin
            r_error    <= 1'b1;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= S_IDLE;
          end else if (i_in_valid) begin
            r_lo    <= i_in_byte;
            r_state <= S_HI;
          end
        end
        S_HI: begin
          if (i_abort) begin
            r_error    <= 1'b1;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= S_IDLE;
          end else if (i_in_valid) begin
            // Write strobe, address, data and checksum all become visible in the WR cycle.
            r_wr_en    <= 1'b1;
            r_wr_data  <= w_word;
            r_wr_addr  <= r_base + r_count[ADDR_W-1:0];
            r_checksum <= r_checksum + w_word;
            r_count    <= w_count_next;
            r_in_ready <= 1'b0;
            r_state    <= S_WR;
          end
        end
        S_WR: begin
          if (i_abort) begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_count == r_len) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_in_ready <= 1'b1;
            r_state    <= S_LO;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready = r_in_ready;
  assign o_wr_en    = r_wr_en;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_wr_data;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_error    = r_error;
  assign o_checksum = r_checksum;

endmodule

// File: tb/tb_weight_ram_loader.sv
// Directed testbench for weight_ram_loader: each task drives one scenario and checks inline.
module tb_weight_ram_loader;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [7:0]  base_addr;
  logic [8:0]  length;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] checksum;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  logic [7:0]  wa_q[$];
  logic [15:0] wd_q[$];
  logic [15:0] wc_q[$];

  weight_ram_loader #(.ADDR_W(8), .DATA_W(16)) dut (
    .i_clk       (clk),
    .i_reset_n   (reset_n),
    .i_start     (start),
    .i_abort     (abort),
    .i_base_addr (base_addr),
    .i_length    (length),
    .i_in_valid  (in_valid),
    .i_in_byte   (in_byte),
    .o_in_ready  (in_ready),
    .o_wr_en     (wr_en),
    .o_wr_addr   (wr_addr),
    .o_wr_data   (wr_data),
    .o_busy      (busy),
    .o_done      (done),
    .o_error     (error),
    .o_checksum  (checksum)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Record every write and every Done pulse seen away from the active edge.
  always @(negedge clk) begin
    if (wr_en) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
      wc_q.push_back(checksum);
      $display("[TB] write addr=%02h data=%04h checksum=%04h", wr_addr, wr_data, checksum);
    end
    if (done) done_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    done_cnt = 0;
  endtask

  task automatic do_start(input logic [7:0] b, input logic [8:0] len);
    in_valid  = 1'b0;
    start     = 1'b1;
    base_addr = b;
    length    = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    k = 0;
    while (!in_ready && k < 50) begin
      in_valid = 1'b0;
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=%0b required 1 for byte %02h", in_ready, b);
    end else begin
      in_valid = 1'b1;
      in_byte  = b;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle(2);
    n_tests++;
    if ({busy, in_ready, wr_en, done, error, wr_addr, wr_data, checksum} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%0b rdy=%0b we=%0b done=%0b err=%0b addr=%h data=%h cks=%h required all 0",
               busy, in_ready, wr_en, done, error, wr_addr, wr_data, checksum);
    end
    reset_n = 1'b1;
    abort   = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    idle(1);
    n_tests++;
    if ({busy, in_ready, error} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_abort: busy/rdy/err=%b required 000", {busy, in_ready, error});
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_basic();
    clear_log();
    do_start(8'h10, 9'd2);
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'h78);
    send_byte(8'h56);
    in_valid = 1'b0;
    idle(5);
    n_tests++;
    if (wa_q.size() !== 2) begin
      n_fail++;
      $display("FAIL basic_nwrites: got %0d required 2", wa_q.size());
    end else begin
      n_tests++;
      if ({wa_q[0], wd_q[0], wa_q[1], wd_q[1]} !== {8'h10, 16'h1234, 8'h11, 16'h5678}) begin
        n_fail++;
        $display("FAIL basic_writes: got %h@%h %h@%h required 1234@10 5678@11",
                 wd_q[0], wa_q[0], wd_q[1], wa_q[1]);
      end
    end
    n_tests++;
    if (checksum !== 16'h68AC) begin
      n_fail++;
      $display("FAIL basic_checksum: got %h required 68ac", checksum);
    end
    n_tests++;
    if (done_cnt !== 1 || error !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_status: done_cycles=%0d err=%0b busy=%0b required 1 0 0", done_cnt, error, busy);
    end
    $display("[TB] test_basic done");
  endtask

  task automatic test_wrap();
    clear_log();
    do_start(8'hFF, 9'd3);
    send_byte(8'hFF); send_byte(8'hFF);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h03); send_byte(8'h00);
    in_valid = 1'b0;
    idle(5);
    n_tests++;
    if (wa_q.size() !== 3) begin
      n_fail++;
      $display("FAIL wrap_nwrites: got %0d required 3", wa_q.size());
    end else begin
      n_tests++;
      if ({wa_q[0], wa_q[1], wa_q[2]} !== {8'hFF, 8'h00, 8'h01}) begin
        n_fail++;
        $display("FAIL wrap_addrs: got %h %h %h required ff 00 01", wa_q[0], wa_q[1], wa_q[2]);
      end
      n_tests++;
      if ({wc_q[0], wc_q[1], wc_q[2]} !== {16'hFFFF, 16'h0001, 16'h0004}) begin
        n_fail++;
        $display("FAIL wrap_checksums: got %h %h %h required ffff 0001 0004", wc_q[0], wc_q[1], wc_q[2]);
      end
    end
    n_tests++;
    if (done_cnt !== 1) begin
      n_fail++;
      $display("FAIL wrap_done: got %0d done cycles required 1", done_cnt);
    end
    $display("[TB] test_wrap done");
  endtask

  task automatic test_stall();
    int bad;
    clear_log();
    bad = 0;
    do_start(8'h20, 9'd1);
    send_byte(8'hCD);
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (in_ready !== 1'b1 || wr_en !== 1'b0) bad++;
      @(negedge clk);
    end
    n_tests++;
    if (bad !== 0 || wa_q.size() !== 0) begin
      n_fail++;
      $display("FAIL stall_hold: got %0d bad cycles, %0d writes required 0 0", bad, wa_q.size());
    end
    send_byte(8'hAB);
    in_valid = 1'b0;
    idle(5);
    n_tests++;
    if (wa_q.size() !== 1) begin
      n_fail++;
      $display("FAIL stall_nwrites: got %0d required 1", wa_q.size());
    end else begin
      n_tests++;
      if ({wa_q[0], wd_q[0]} !== {8'h20, 16'hABCD}) begin
        n_fail++;
        $display("FAIL stall_write: got %h@%h required abcd@20", wd_q[0], wa_q[0]);
      end
    end
    $display("[TB] test_stall done");
  endtask

  task automatic test_bad_length();
    clear_log();
    do_start(8'h00, 9'd0);
    idle(1);
    n_tests++;
    if ({error, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL len0: err/busy=%b required 10", {error, busy});
    end
    do_start(8'h00, 9'd257);
    idle(2);
    n_tests++;
    if ({error, busy, in_ready} !== 3'b100 || wa_q.size() !== 0) begin
      n_fail++;
      $display("FAIL len257: err/busy/rdy=%b writes=%0d required 100 0", {error, busy, in_ready}, wa_q.size());
    end
    $display("[TB] test_bad_length done");
  endtask

  task automatic test_full();
    int bad;
    logic [15:0] exp_cks;
    logic [7:0]  lo;
    clear_log();
    do_start(8'h00, 9'd256);
    n_tests++;
    if ({error, busy, in_ready} !== 3'b011) begin
      n_fail++;
      $display("FAIL full_start: err/busy/rdy=%b required 011", {error, busy, in_ready});
    end
    exp_cks = 16'h0000;
    for (int i = 0; i < 256; i++) begin
      lo = 8'(i);
      send_byte(lo);
      send_byte(lo ^ 8'h5A);
      exp_cks = exp_cks + {lo ^ 8'h5A, lo};
    end
    in_valid = 1'b0;
    idle(5);
    n_tests++;
    if (wa_q.size() !== 256) begin
      n_fail++;
      $display("FAIL full_nwrites: got %0d required 256", wa_q.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 256; i++) begin
        lo = 8'(i);
        if (wa_q[i] !== lo || wd_q[i] !== {lo ^ 8'h5A, lo}) bad++;
      end
      n_tests++;
      if (bad !== 0) begin
        n_fail++;
        $display("FAIL full_writes: got %0d wrong addr/data entries required 0", bad);
      end
    end
    n_tests++;
    if (checksum !== exp_cks || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL full_end: cks=%h done=%0d required %h 1", checksum, done_cnt, exp_cks);
    end
    $display("[TB] test_full done");
  endtask

  task automatic test_abort();
    clear_log();
    do_start(8'h40, 9'd4);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    in_valid = 1'b0;
    abort    = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    idle(4);
    n_tests++;
    if (wa_q.size() !== 1 || {error, busy, in_ready} !== 3'b100 || done_cnt !== 0) begin
      n_fail++;
      $display("FAIL abort_state: writes=%0d err/busy/rdy=%b done=%0d required 1 100 0",
               wa_q.size(), {error, busy, in_ready}, done_cnt);
    end
    n_tests++;
    if (checksum !== 16'h2211) begin
      n_fail++;
      $display("FAIL abort_checksum: got %h required 2211", checksum);
    end
    clear_log();
    do_start(8'h50, 9'd1);
    send_byte(8'h99);
    send_byte(8'h88);
    in_valid = 1'b0;
    idle(5);
    n_tests++;
    if (wa_q.size() !== 1 || error !== 1'b0 || done_cnt !== 1 || checksum !== 16'h8899) begin
      n_fail++;
      $display("FAIL abort_reload: writes=%0d err=%0b done=%0d cks=%h required 1 0 1 8899",
               wa_q.size(), error, done_cnt, checksum);
    end else begin
      n_tests++;
      if ({wa_q[0], wd_q[0]} !== {8'h50, 16'h8899}) begin
        n_fail++;
        $display("FAIL abort_reload_write: got %h@%h required 8899@50", wd_q[0], wa_q[0]);
      end
    end
    $display("[TB] test_abort done");
  endtask

  task automatic test_mid_reset();
    clear_log();
    do_start(8'h60, 9'd2);
    send_byte(8'h01);
    reset_n = 1'b0;
    in_byte = 8'h02;
    @(negedge clk);
    n_tests++;
    if ({busy, in_ready, wr_en, done, error, wr_addr, wr_data, checksum} !== '0 || wa_q.size() !== 0) begin
      n_fail++;
      $display("FAIL midreset_outputs: busy=%0b rdy=%0b we=%0b done=%0b err=%0b addr=%h data=%h cks=%h writes=%0d required all 0",
               busy, in_ready, wr_en, done, error, wr_addr, wr_data, checksum, wa_q.size());
    end
    in_valid = 1'b0;
    reset_n  = 1'b1;
    idle(3);
    n_tests++;
    if (wa_q.size() !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_after: writes=%0d busy=%0b required 0 0", wa_q.size(), busy);
    end
    $display("[TB] test_mid_reset done");
  endtask

  task automatic test_start_busy();
    clear_log();
    do_start(8'h70, 9'd2);
    send_byte(8'hAA);
    send_byte(8'hBB);
    in_valid  = 1'b0;
    start     = 1'b1;
    base_addr = 8'h00;
    length    = 9'd1;
    idle(2);
    start = 1'b0;
    send_byte(8'hCC);
    send_byte(8'hDD);
    in_valid = 1'b0;
    idle(5);
    n_tests++;
    if (wa_q.size() !== 2) begin
      n_fail++;
      $display("FAIL busy_start_nwrites: got %0d required 2", wa_q.size());
    end else begin
      n_tests++;
      if ({wa_q[0], wd_q[0], wa_q[1], wd_q[1]} !== {8'h70, 16'hBBAA, 8'h71, 16'hDDCC}) begin
        n_fail++;
        $display("FAIL busy_start_writes: got %h@%h %h@%h required bbaa@70 ddcc@71",
                 wd_q[0], wa_q[0], wd_q[1], wa_q[1]);
      end
    end
    n_tests++;
    if (checksum !== 16'h9976 || done_cnt !== 1 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start_end: cks=%h done=%0d err=%0b required 9976 1 0", checksum, done_cnt, error);
    end
    $display("[TB] test_start_busy done");
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    base_addr = 8'h00;
    length    = 9'd0;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    @(negedge clk);
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_bad_length();
    test_full();
    test_abort();
    test_mid_reset();
    test_start_busy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_ram_loader.md
Name: weight_ram_loader

Overview:
- Writer-side counterpart to the weight RAM read path: accepts a byte stream, assembles 16-bit little-endian words, and writes them sequentially into the RAM write port from a programmable base address.
- Sits between the byte source (UART/JTAG bridge, test bench) and the RAM write port.
- Produces a 16-bit running checksum of the written words so the load can be confirmed on the hex displays.

Parameters:
- ADDR_W, 8, RAM address width; depth is 2**ADDR_W words.
- DATA_W, 16, RAM word width; fixed at 2 bytes per word.

Ports:
- Clk  input  1  system clock (50 MHz); all logic on rising edge.
- Reset_n  input  1  reset; one clock, synchronous, active-low.
- Start  input  1  begin a load; sampled only in IDLE.
- Abort  input  1  cancel an in-progress load.
- Base_addr  input  ADDR_W  first word address; latched on accepted Start.
- Length  input  ADDR_W+1  number of words, valid range 1..2**ADDR_W; latched on accepted Start.
- In_valid  input  1  In_byte is valid.
- In_byte  input  8  stream byte, low byte of each word first.
- In_ready  output  1  loader accepts a byte this cycle.
- Wr_en  output  1  RAM write strobe.
- Wr_addr  output  ADDR_W  RAM write address.
- Wr_data  output  DATA_W  RAM write data.
- Busy  output  1  load in progress.
- Done  output  1  one-cycle pulse on successful completion.
- Error  output  1  sticky: bad Length or Abort; cleared by the next accepted Start.
- Checksum  output  16  sum mod 2^16 of all words written in the current or last load.

Behaviour:
- Reset (Reset_n=0 at a rising edge):
  - State becomes IDLE.
  - All outputs are 0 from the following cycle, including Wr_addr, Wr_data and Checksum.
  - Any partially assembled word is discarded and no write is issued.
  - Reset overrides Start and Abort.
- States: IDLE, LO, HI, WR, DONE. Busy=1 in LO, HI and WR. In_ready=1 only in LO and HI.
- IDLE:
  - Start=1 with Length in 1..2**ADDR_W:
    - Latch Base_addr and Length.
    - Clear the word counter and Checksum; clear Error.
    - Go to LO.
  - Start=1 with Length=0 or Length>2**ADDR_W: set Error=1, stay in IDLE, no writes.
- LO: on In_valid=1, capture In_byte as the low byte and go to HI. With In_valid=0, hold indefinitely.
- HI: on In_valid=1, capture In_byte as the high byte and go to WR.
- WR (exactly one cycle):
  - Wr_en=1, Wr_data={hi,lo}.
  - Wr_addr=(Base_addr+count) mod 2**ADDR_W, so addresses wrap past the top of the RAM.
  - Checksum += word, mod 2^16 with overflow discarded.
  - count increments.
  - If the new count equals Length, go to DONE; otherwise go to LO.
  - In_ready=0 in WR, so at most 1 word per 3 cycles.
- DONE: Done=1 for one cycle, Busy=0, then IDLE.
- Wr_en is registered and asserted only during the WR cycle. Wr_addr and Wr_data hold their last values while Wr_en=0.
- Checksum holds its final value after DONE or Abort until the next accepted Start.
- Abort=1 in LO, HI or WR:
  - Next state is IDLE; Error=1; Done is not asserted.
  - Abort in the WR cycle still completes that cycle's write, because Wr_en is already registered; no further writes follow.
  - Abort in IDLE or DONE has no effect.
- Start while Busy is ignored; the latched parameters are unchanged.
- Simultaneous Start and Abort in IDLE: Start wins.

Test Plan:
1. Base_addr=0x10, Length=2, bytes 0x34 0x12 0x78 0x56 back-to-back -> writes 0x1234@0x10 and 0x5678@0x11, each with a single-cycle Wr_en; Checksum=0x68AC; one-cycle Done; Error=0.
2. Wrap: Base_addr=0xFF, Length=3 -> Wr_addr sequence 0xFF, 0x00, 0x01. Words 0xFFFF and 0x0002 give an intermediate Checksum of 0x0001.
3. Stall: In_valid deasserted for 10 cycles between low and high byte -> no Wr_en until the high byte is accepted; In_ready stays 1; the written word is correct.
4. Length=0, then Length=257 -> Error=1, Busy=0, no Wr_en. A following valid Start clears Error. Length=256 at Base_addr=0 -> 256 writes covering 0x00..0xFF, then Done.
5. Abort after the first byte of word 2 (Length=4) -> exactly 1 write, Error=1, returns to IDLE, no Done. A new Start then loads normally.
6. Reset_n=0 mid-load, during HI -> next cycle all outputs are 0 and no write is issued. Start asserted while Busy -> ignored; Base_addr and Length are unchanged.
